// File: rtl/cvd_throw_pkg.sv
// Shared throw/projectile types and screen constants for the cat-vs-dog game blocks.
// Positions are Q12.4, velocities Q8.4, all two's complement.
package cvd_throw_pkg;

  localparam int FRAC_W = 4;
  localparam int POS_W  = 16;
  localparam int VEL_W  = 12;
  localparam int INT_W  = POS_W - FRAC_W;
  localparam int PIX_W  = 11;
  localparam int PWR_W  = 7;
  localparam int WIND_W = 4;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_CHARGE = 3'd1;
  localparam state_t S_LAUNCH = 3'd2;
  localparam state_t S_FLY    = 3'd3;
  localparam state_t S_RESULT = 3'd4;

  localparam int DEF_SCREEN_W   = 1024;
  localparam int DEF_GROUND_Y   = 700;
  localparam int DEF_START_Y    = 600;
  localparam int DEF_CAT_X0     = 100;
  localparam int DEF_DOG_X0     = 900;
  localparam int DEF_CAT_BOX_XL = 60;
  localparam int DEF_CAT_BOX_XH = 140;
  localparam int DEF_CAT_BOX_YL = 560;
  localparam int DEF_CAT_BOX_YH = 700;
  localparam int DEF_DOG_BOX_XL = 860;
  localparam int DEF_DOG_BOX_XH = 940;
  localparam int DEF_DOG_BOX_YL = 560;
  localparam int DEF_DOG_BOX_YH = 700;
  localparam int DEF_PWR_MAX    = 100;
  localparam int DEF_GRAVITY    = 3;

endpackage

// File: rtl/throw_projectile_ctrl_if.sv
// Turn-control / draw-pipeline side signals of the throw controller.
interface throw_projectile_ctrl_if;
  import cvd_throw_pkg::*;

  logic                     frame_tick;
  logic                     dog_turn;
  logic                     enable_draw;
  logic                     throw_enable;
  logic signed [WIND_W-1:0] wind;
  logic [PWR_W-1:0]         power;
  logic [PIX_W-1:0]         proj_x;
  logic [PIX_W-1:0]         proj_y;
  logic                     proj_visible;
  logic                     hit;
  logic                     miss;
  logic                     done;

  modport master (
    output frame_tick, dog_turn, enable_draw, throw_enable, wind,
    input  power, proj_x, proj_y, proj_visible, hit, miss, done
  );

  modport slave (
    input  frame_tick, dog_turn, enable_draw, throw_enable, wind,
    output power, proj_x, proj_y, proj_visible, hit, miss, done
  );

endinterface

// File: rtl/box_hit_check.sv
// Inclusive point-in-rectangle test on signed integer pixel coordinates.
module box_hit_check
  import cvd_throw_pkg::*;
(
  input  logic signed [INT_W-1:0] px_i,
  input  logic signed [INT_W-1:0] py_i,
  input  logic signed [INT_W-1:0] xl_i,
  input  logic signed [INT_W-1:0] xh_i,
  input  logic signed [INT_W-1:0] yl_i,
  input  logic signed [INT_W-1:0] yh_i,
  output logic                    inside_o
);

  assign inside_o = (px_i >= xl_i) && (px_i <= xh_i) &&
                    (py_i >= yl_i) && (py_i <= yh_i);

endmodule

// File: rtl/throw_projectile_ctrl.sv
// Throw power meter plus one ballistic projectile per throw, stepped once per frame,
// reporting hit/miss of the opponent's box to the game controller.
module throw_projectile_ctrl
  import cvd_throw_pkg::*;
#(
  parameter int SCREEN_W   = DEF_SCREEN_W,
  parameter int GROUND_Y   = DEF_GROUND_Y,
  parameter int START_Y    = DEF_START_Y,
  parameter int CAT_X0     = DEF_CAT_X0,
  parameter int DOG_X0     = DEF_DOG_X0,
  parameter int CAT_BOX_XL = DEF_CAT_BOX_XL,
  parameter int CAT_BOX_XH = DEF_CAT_BOX_XH,
  parameter int CAT_BOX_YL = DEF_CAT_BOX_YL,
  parameter int CAT_BOX_YH = DEF_CAT_BOX_YH,
  parameter int DOG_BOX_XL = DEF_DOG_BOX_XL,
  parameter int DOG_BOX_XH = DEF_DOG_BOX_XH,
  parameter int DOG_BOX_YL = DEF_DOG_BOX_YL,
  parameter int DOG_BOX_YH = DEF_DOG_BOX_YH,
  parameter int PWR_MAX    = DEF_PWR_MAX,
  parameter int GRAVITY    = DEF_GRAVITY
) (
  input logic clk,
  input logic rst,
  throw_projectile_ctrl_if.slave ctrl
);

  localparam logic [PWR_W-1:0]         PMAX     = PWR_W'(PWR_MAX);
  localparam logic signed [INT_W-1:0]  XMAX     = INT_W'(SCREEN_W - 1);
  localparam logic signed [INT_W-1:0]  YGND     = INT_W'(GROUND_Y);
  localparam logic signed [POS_W-1:0]  CAT_X0_Q = POS_W'(CAT_X0 << FRAC_W);
  localparam logic signed [POS_W-1:0]  DOG_X0_Q = POS_W'(DOG_X0 << FRAC_W);
  localparam logic signed [POS_W-1:0]  START_Q  = POS_W'(START_Y << FRAC_W);
  localparam logic signed [VEL_W-1:0]  GRAV_Q   = VEL_W'(GRAVITY);

  state_t                    state_q, state_d;
  logic                      te_q;
  logic [PWR_W-1:0]          power_q, power_d;
  logic                      pwr_up_q, pwr_up_d;
  logic                      dir_q, dir_d;
  logic signed [WIND_W-1:0]  wind_q, wind_d;
  logic signed [POS_W-1:0]   x_q, x_d, y_q, y_d;
  logic signed [VEL_W-1:0]   vx_q, vx_d, vy_q, vy_d;
  logic                      chk_q, chk_d;
  logic                      vis_q, vis_d;
  logic                      hit_q, hit_d, miss_q, miss_d, done_q, done_d;

  logic                      te_rise;
  logic signed [VEL_W-1:0]   pwr_v, pwr2_v;
  logic signed [INT_W-1:0]   x_int, y_int;
  logic signed [INT_W-1:0]   bxl, bxh, byl, byh;
  logic                      in_box, off_screen, on_ground;

  assign te_rise = ctrl.throw_enable & ~te_q;
  assign pwr_v   = {{(VEL_W-PWR_W){1'b0}}, power_q};
  assign pwr2_v  = {pwr_v[VEL_W-2:0], 1'b0};
  assign x_int   = x_q[POS_W-1:FRAC_W];
  assign y_int   = y_q[POS_W-1:FRAC_W];

  // The thrower's own box is never tested: the dog aims at the cat and vice versa.
  assign bxl = dir_q ? INT_W'(CAT_BOX_XL) : INT_W'(DOG_BOX_XL);
  assign bxh = dir_q ? INT_W'(CAT_BOX_XH) : INT_W'(DOG_BOX_XH);
  assign byl = dir_q ? INT_W'(CAT_BOX_YL) : INT_W'(DOG_BOX_YL);
  assign byh = dir_q ? INT_W'(CAT_BOX_YH) : INT_W'(DOG_BOX_YH);

  box_hit_check u_box (
    .px_i     (x_int),
    .py_i     (y_int),
    .xl_i     (bxl),
    .xh_i     (bxh),
    .yl_i     (byl),
    .yh_i     (byh),
    .inside_o (in_box)
  );

  assign on_ground  = (y_int >= YGND);
  assign off_screen = x_int[INT_W-1] || (x_int > XMAX);

  always_comb begin
    state_d  = state_q;
    power_d  = power_q;
    pwr_up_d = pwr_up_q;
    dir_d    = dir_q;
    wind_d   = wind_q;
    x_d      = x_q;
    y_d      = y_q;
    vx_d     = vx_q;
    vy_d     = vy_q;
    chk_d    = 1'b0;
    vis_d    = vis_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ctrl.enable_draw) begin
          state_d  = S_CHARGE;
          power_d  = '0;
          pwr_up_d = 1'b1;
        end else if (te_rise) begin
          state_d = S_LAUNCH;
        end
      end

      S_CHARGE: begin
        if (!ctrl.enable_draw && te_rise) begin
          state_d = S_LAUNCH;
        end else if (!ctrl.enable_draw && !ctrl.throw_enable) begin
          state_d = S_IDLE;
        end else if (ctrl.frame_tick) begin
          if (pwr_up_q) begin
            if (power_q >= PMAX) begin
              power_d  = PMAX - 1'b1;
              pwr_up_d = 1'b0;
            end else begin
              power_d = power_q + 1'b1;
            end
          end else if (power_q == '0) begin
            power_d  = PWR_W'(1);
            pwr_up_d = 1'b1;
          end else begin
            power_d = power_q - 1'b1;
          end
        end
      end

      S_LAUNCH: begin
        dir_d   = ctrl.dog_turn;
        wind_d  = ctrl.wind;
        x_d     = ctrl.dog_turn ? DOG_X0_Q : CAT_X0_Q;
        y_d     = START_Q;
        vx_d    = ctrl.dog_turn ? -pwr2_v : pwr2_v;
        vy_d    = -pwr_v;
        vis_d   = 1'b1;
        state_d = S_FLY;
      end

      // A frame updates position first from the old velocity; the following
      // cycle judges the new position before the next frame can move it.
      S_FLY: begin
        if (chk_q) begin
          if (in_box) begin
            hit_d   = 1'b1;
            done_d  = 1'b1;
            vis_d   = 1'b0;
            state_d = S_RESULT;
          end else if (on_ground || off_screen) begin
            miss_d  = 1'b1;
            done_d  = 1'b1;
            vis_d   = 1'b0;
            state_d = S_RESULT;
          end
        end else if (ctrl.frame_tick) begin
          x_d   = x_q + {{(POS_W-VEL_W){vx_q[VEL_W-1]}}, vx_q};
          y_d   = y_q + {{(POS_W-VEL_W){vy_q[VEL_W-1]}}, vy_q};
          vy_d  = vy_q + GRAV_Q;
          vx_d  = vx_q + {{(VEL_W-WIND_W){wind_q[WIND_W-1]}}, wind_q};
          chk_d = 1'b1;
        end
      end

      S_RESULT: begin
        vis_d   = 1'b0;
        power_d = '0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      te_q     <= 1'b0;
      power_q  <= '0;
      pwr_up_q <= 1'b1;
      dir_q    <= 1'b0;
      wind_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      vx_q     <= '0;
      vy_q     <= '0;
      chk_q    <= 1'b0;
      vis_q    <= 1'b0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      te_q     <= ctrl.throw_enable;
      power_q  <= power_d;
      pwr_up_q <= pwr_up_d;
      dir_q    <= dir_d;
      wind_q   <= wind_d;
      x_q      <= x_d;
      y_q      <= y_d;
      vx_q     <= vx_d;
      vy_q     <= vy_d;
      chk_q    <= chk_d;
      vis_q    <= vis_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      done_q   <= done_d;
    end
  end

  assign ctrl.power        = power_q;
  assign ctrl.proj_x       = x_q[FRAC_W+PIX_W-1:FRAC_W];
  assign ctrl.proj_y       = y_q[FRAC_W+PIX_W-1:FRAC_W];
  assign ctrl.proj_visible = vis_q;
  assign ctrl.hit          = hit_q;
  assign ctrl.miss         = miss_q;
  assign ctrl.done         = done_q;

endmodule

// File: tb/tb_throw_projectile_ctrl.sv
// Self-checking bench for throw_projectile_ctrl against a frame-level ballistic model.
module tb_throw_projectile_ctrl;
  import cvd_throw_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  throw_projectile_ctrl_if bus ();

  throw_projectile_ctrl dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (bus)
  );

  always #5 clk = ~clk;

  // All driving and sampling happens on the falling edge, away from the active edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic tick();
    bus.frame_tick = 1'b1;
    cyc();
    bus.frame_tick = 1'b0;
  endtask

  // Triangle wave of period 2*PWR_MAX starting at 0.
  function automatic int model_power(input int ticks);
    int m;
    m = ticks % 200;
    return (m <= 100) ? m : 200 - m;
  endfunction

  task automatic charge(input int n);
    bus.throw_enable = 1'b0;
    bus.enable_draw  = 1'b1;
    cyc();
    for (int k = 0; k < n; k++) begin
      tick();
      cyc();
    end
  endtask

  task automatic launch();
    bus.enable_draw  = 1'b0;
    bus.throw_enable = 1'b1;
    cyc();
    cyc();
  endtask

  task automatic fly_check(input string name, input bit dog, input int pwr, input int wnd,
                           input bit wiggle, input bit retrig,
                           output int frames, output bit was_hit);
    int x, y, vx, vy, xi, yi;
    logic [15:0] xr, yr;
    bit m_hit, m_miss, ended;
    x = (dog ? 900 : 100) * 16;
    y = 600 * 16;
    vx = dog ? -2 * pwr : 2 * pwr;
    vy = -pwr;
    frames = 0;
    was_hit = 1'b0;
    ended = 1'b0;
    checks++;
    if (bus.proj_visible !== 1'b1 || bus.proj_x !== 11'(x / 16) || bus.proj_y !== 11'(600)) begin
      errors++;
      $display("[TB] FAIL %s launch: vis=%0b x=%0d y=%0d expected vis=1 x=%0d y=600",
               name, bus.proj_visible, bus.proj_x, bus.proj_y, x / 16);
    end
    for (int f = 1; f <= 300 && !ended; f++) begin
      if (wiggle) begin
        bus.dog_turn    = 1'($urandom);
        bus.wind        = 4'($urandom);
        bus.enable_draw = 1'($urandom);
      end
      if (retrig && f == 5) begin
        bus.throw_enable = 1'b0;
        cyc();
        bus.throw_enable = 1'b1;
      end
      tick();
      x  = x + vx;
      y  = y + vy;
      vy = vy + 3;
      vx = vx + wnd;
      xr = 16'(x);
      yr = 16'(y);
      checks++;
      if (bus.proj_x !== xr[14:4] || bus.proj_y !== yr[14:4]) begin
        errors++;
        $display("[TB] FAIL %s frame %0d position: got (%0d,%0d) expected (%0d,%0d)",
                 name, f, bus.proj_x, bus.proj_y, xr[14:4], yr[14:4]);
      end
      xi = x >>> 4;
      yi = y >>> 4;
      if (dog) m_hit = (xi >= 60 && xi <= 140 && yi >= 560 && yi <= 700);
      else     m_hit = (xi >= 860 && xi <= 940 && yi >= 560 && yi <= 700);
      m_miss = !m_hit && (yi >= 700 || xi < 0 || xi > 1023);
      cyc();
      checks++;
      if ({bus.hit, bus.miss, bus.done, bus.proj_visible} !==
          {m_hit, m_miss, m_hit | m_miss, !(m_hit | m_miss)}) begin
        errors++;
        $display("[TB] FAIL %s frame %0d result: hit/miss/done/vis=%b%b%b%b expected %b%b%b%b",
                 name, f, bus.hit, bus.miss, bus.done, bus.proj_visible,
                 m_hit, m_miss, m_hit | m_miss, !(m_hit | m_miss));
      end
      if (m_hit || m_miss) begin
        ended = 1'b1;
        frames = f;
        was_hit = m_hit;
        bus.enable_draw = 1'b0;
        bus.dog_turn = 1'b0;
        bus.wind = '0;
        cyc();
        checks++;
        if ({bus.hit, bus.miss, bus.done, bus.proj_visible} !== 4'b0000 || bus.power !== 7'd0) begin
          errors++;
          $display("[TB] FAIL %s after result: hit/miss/done/vis=%b%b%b%b power=%0d expected 0000 power=0",
                   name, bus.hit, bus.miss, bus.done, bus.proj_visible, bus.power);
        end
      end else begin
        repeat ($urandom_range(0, 2)) cyc();
      end
    end
    if (!ended) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: no result within 300 frames", name);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.frame_tick = 1'b0;
    bus.dog_turn = 1'b0;
    bus.enable_draw = 1'b0;
    bus.throw_enable = 1'b0;
    bus.wind = '0;
    cyc();
    cyc();
    rst = 1'b0;
    checks++;
    if (bus.power !== 7'd0 || bus.proj_x !== 11'd0 || bus.proj_y !== 11'd0) begin
      errors++;
      $display("[TB] FAIL reset values: power=%0d x=%0d y=%0d expected 0", bus.power, bus.proj_x, bus.proj_y);
    end
    checks++;
    if ({bus.proj_visible, bus.hit, bus.miss, bus.done} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset flags: vis/hit/miss/done=%b%b%b%b expected 0000",
               bus.proj_visible, bus.hit, bus.miss, bus.done);
    end
  endtask

  task automatic test_charge_pingpong();
    int fr;
    bit h;
    bus.dog_turn = 1'b0;
    bus.wind = '0;
    bus.throw_enable = 1'b0;
    bus.enable_draw = 1'b1;
    cyc();
    checks++;
    if (bus.power !== 7'd0) begin
      errors++;
      $display("[TB] FAIL charge start: power=%0d expected 0", bus.power);
    end
    for (int k = 1; k <= 150; k++) begin
      tick();
      checks++;
      if (bus.power !== 7'(model_power(k))) begin
        errors++;
        $display("[TB] FAIL charge tick %0d: power=%0d expected %0d", k, bus.power, model_power(k));
      end
      cyc();
    end
    bus.enable_draw = 1'b0;
    bus.throw_enable = 1'b1;
    cyc();
    checks++;
    if (bus.proj_visible !== 1'b0) begin
      errors++;
      $display("[TB] FAIL launch latency: vis=%0b one cycle after edge, expected 0", bus.proj_visible);
    end
    cyc();
    checks++;
    if (bus.power !== 7'd50) begin
      errors++;
      $display("[TB] FAIL launch power: power=%0d expected 50", bus.power);
    end
    fly_check("cat_p50", 1'b0, 50, 0, 1'b0, 1'b0, fr, h);
    bus.throw_enable = 1'b0;
    cyc();
  endtask

  task automatic test_zero_power_drop();
    int fr;
    bit h;
    bus.dog_turn = 1'b1;
    bus.wind = '0;
    launch();
    fly_check("dog_p0", 1'b1, 0, 0, 1'b0, 1'b0, fr, h);
    checks++;
    if (fr !== 34 || h !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero-power drop: ended frame %0d hit=%0b expected frame 34 hit=0", fr, h);
    end
    bus.throw_enable = 1'b0;
    bus.dog_turn = 1'b0;
    cyc();
  endtask

  task automatic test_abort();
    int fr;
    bit h;
    charge(7);
    bus.enable_draw = 1'b0;
    cyc();
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (bus.power !== 7'd7 || bus.proj_visible !== 1'b0) begin
        errors++;
        $display("[TB] FAIL abort hold %0d: power=%0d vis=%0b expected power=7 vis=0",
                 k, bus.power, bus.proj_visible);
      end
      cyc();
    end
    bus.dog_turn = 1'b0;
    launch();
    fly_check("idle_launch_p7", 1'b0, 7, 0, 1'b0, 1'b0, fr, h);
    bus.throw_enable = 1'b0;
    cyc();
  endtask

  task automatic test_cat_full_power();
    int fr;
    bit h;
    bus.dog_turn = 1'b0;
    bus.wind = '0;
    charge(100);
    checks++;
    if (bus.power !== 7'd100) begin
      errors++;
      $display("[TB] FAIL full charge: power=%0d expected 100", bus.power);
    end
    launch();
    fly_check("cat_p100", 1'b0, 100, 0, 1'b0, 1'b0, fr, h);
    checks++;
    if (h !== 1'b1 || fr !== 61) begin
      errors++;
      $display("[TB] FAIL cat full power: hit=%0b frame=%0d expected hit=1 frame=61", h, fr);
    end
    bus.throw_enable = 1'b0;
    cyc();
  endtask

  task automatic test_back_to_back();
    int fr;
    bit h;
    bus.dog_turn = 1'b1;
    bus.wind = 4'sd2;
    charge(80);
    launch();
    fly_check("retrigger", 1'b1, 80, 2, 1'b0, 1'b1, fr, h);
    for (int k = 0; k < 6; k++) begin
      cyc();
      checks++;
      if (bus.proj_visible !== 1'b0 || bus.done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL retrigger relaunch %0d: vis=%0b done=%0b expected 0 0",
                 k, bus.proj_visible, bus.done);
      end
    end
    bus.throw_enable = 1'b0;
    cyc();
  endtask

  task automatic test_reset_midflight();
    bus.dog_turn = 1'b0;
    bus.wind = '0;
    charge(60);
    launch();
    for (int f = 0; f < 10; f++) begin
      tick();
      cyc();
    end
    rst = 1'b1;
    bus.throw_enable = 1'b0;
    cyc();
    rst = 1'b0;
    checks++;
    if (bus.power !== 7'd0 || bus.proj_x !== 11'd0 || bus.proj_y !== 11'd0 ||
        {bus.proj_visible, bus.hit, bus.miss, bus.done} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset mid-flight: power=%0d x=%0d y=%0d vis/hit/miss/done=%b%b%b%b expected all 0",
               bus.power, bus.proj_x, bus.proj_y, bus.proj_visible, bus.hit, bus.miss, bus.done);
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if ({bus.proj_visible, bus.hit, bus.miss, bus.done} !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL post-reset %0d: vis/hit/miss/done=%b%b%b%b expected 0000",
                 k, bus.proj_visible, bus.hit, bus.miss, bus.done);
      end
    end
  endtask

  task automatic test_random_throws();
    int fr, n, w, p;
    bit h, dog;
    for (int i = 0; i < 6; i++) begin
      dog = 1'($urandom_range(0, 1));
      n   = $urandom_range(1, 250);
      w   = $urandom_range(0, 15) - 8;
      p   = model_power(n);
      bus.dog_turn = dog;
      bus.wind = 4'(w);
      charge(n);
      checks++;
      if (bus.power !== 7'(p)) begin
        errors++;
        $display("[TB] FAIL random %0d charge: power=%0d expected %0d", i, bus.power, p);
      end
      launch();
      $display("[TB] random throw %0d: dog=%0b power=%0d wind=%0d", i, dog, p, w);
      fly_check("random", dog, p, w, 1'b1, 1'b0, fr, h);
      bus.throw_enable = 1'b0;
      cyc();
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_charge_pingpong();
    test_zero_power_drop();
    test_abort();
    test_cat_full_power();
    test_back_to_back();
    test_reset_midflight();
    test_random_throws();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/throw_projectile_ctrl.md
Name: throw_projectile_ctrl

Overview:
- Sits directly downstream of the local turn FSM.
- Consumes `enable_draw` (charge phase) and `throw_enable` (release) and turns them into a throw power meter.
- Launches one ballistic projectile per throw, steps it once per frame, and reports hit or miss to the game controller.
- Drives the projectile sprite position for the draw pipeline.

Parameters:
- SCREEN_W, 1024, horizontal extent in pixels; x outside 0..SCREEN_W-1 is a miss.
- GROUND_Y, 700, y at or below this value (y >= GROUND_Y) is a miss.
- START_Y, 600, launch y for both throwers.
- CAT_X0, 100, launch x when the cat throws.
- DOG_X0, 900, launch x when the dog throws.
- CAT_BOX_XL/XH/YL/YH, 60/140/560/700, cat hit box, inclusive.
- DOG_BOX_XL/XH/YL/YH, 860/940/560/700, dog hit box, inclusive.
- PWR_MAX, 100, power meter ceiling.
- GRAVITY, 3, added to vy each frame, in Q.4 units (3/16 px/frame²).

Ports:
- clk  in  1  system clock (65 MHz)
- rst  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per video frame
- dog_turn  in  1  1 = dog throws (right to left), 0 = cat throws (left to right)
- enable_draw  in  1  charge active (space held)
- throw_enable  in  1  release window; rising edge launches
- wind  in  4  signed wind, Q.4 px/frame², added to vx each frame
- power  out  7  current meter value, 0..PWR_MAX
- proj_x  out  11  projectile integer x
- proj_y  out  11  projectile integer y
- proj_visible  out  1  projectile in flight
- hit  out  1  one-cycle pulse, opponent box struck
- miss  out  1  one-cycle pulse, ground or off-screen
- done  out  1  one-cycle pulse with hit or miss

Behaviour:
- Reset values: all outputs 0, state IDLE, internal position/velocity 0, power direction = up, throw_enable edge register 0.
- Position registers are 16-bit signed Q12.4. proj_x and proj_y are bits [14:4] of x and y.
- Velocity registers are 12-bit signed Q8.4.
- Arithmetic is two's complement. Because bounds are checked every frame, no saturation is needed.
- throw_enable rising edge (`te_rise`) = throw_enable & ~te_q, where te_q is throw_enable registered each cycle.
- States:
  - IDLE:
    - enable_draw=1 -> CHARGE, power := 0, direction := up.
    - te_rise -> LAUNCH with the held power value.
  - CHARGE:
    - On each frame_tick, power ping-pongs: +1 up to PWR_MAX, then -1 down to 0, then up again.
    - At a turn point the next value is the reversed step (PWR_MAX -> PWR_MAX-1; 0 -> 1).
    - enable_draw=0 and te_rise -> LAUNCH.
    - enable_draw=0 and throw_enable=0 -> IDLE (aborted); power is held.
  - LAUNCH (one cycle):
    - Latch dir := dog_turn and wind.
    - x := (dir ? DOG_X0 : CAT_X0) << 4; y := START_Y << 4.
    - vx := dir ? -2*power : +2*power; vy := -power.
    - proj_visible := 1 -> FLY.
  - FLY:
    - On each frame_tick, in this order:
      1. x += vx; y += vy (using the old velocities).
      2. vy += GRAVITY; vx += wind.
    - The cycle after each update, evaluate in priority order:
      1. Integer (x,y) inside the opponent box -> RESULT(hit). The opponent box is CAT_BOX if dir=1, else DOG_BOX.
      2. y >= GROUND_Y -> RESULT(miss).
      3. x < 0 or x > SCREEN_W-1 -> RESULT(miss).
    - The thrower's own box is never checked.
  - RESULT (one cycle):
    - Pulse done plus hit or miss.
    - proj_visible := 0; power := 0 -> IDLE.
- In LAUNCH, FLY and RESULT, enable_draw, throw_enable, dog_turn and wind changes are ignored. A te_rise during flight is dropped, not queued.
- frame_tick arriving in the same cycle as the LAUNCH or RESULT state is ignored.
- rst mid-flight: everything returns to reset values next cycle; no done pulse is produced.
- Latency: te_rise to proj_visible = 2 cycles (edge detect, LAUNCH). Final frame_tick to done = 2 cycles.

Decomposition:
- A package `cvd_throw_pkg` holds the state enum, Q-format widths, and the default screen and box constants, shared with the draw and game-control blocks.
- One sub-module, `box_hit_check`: combinational inclusive point-in-rectangle test, instantiated once with a muxed box.

Test Plan:
1. Charge ping-pong: enable_draw=1 for 150 frame_ticks -> power reaches 100 at tick 100, then 50 at tick 150. Then enable_draw=0 and throw_enable=1 the next cycle -> launch with power 50, vx=+100 for cat, vy=-50.
2. Zero-power drop: dog_turn=1, power 0, te_rise -> proj_x stays 900. Miss and done pulse after the 34th frame_tick (y = 600 + floor(1683/16) = 705); no hit on the dog's own box.
3. Abort: enable_draw 1->0 with throw_enable held 0 -> IDLE, power held, proj_visible never asserts.
4. Cat full-power hit: power 100, wind 0, dog_turn=0 -> compare proj_x/proj_y per frame against a reference model. Exactly one of hit/miss pulses, coincident with done, and proj_visible drops in the same cycle.
5. Re-trigger: throw_enable held high through the whole flight plus a second rising edge mid-flight -> no relaunch, a single done.
6. Reset mid-flight: assert rst at frame 10 -> next cycle all outputs 0, state IDLE, no done/hit/miss.
